// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one recoding step per clock over WIDTH+1
// extended bits, so signed and unsigned operands share the same datapath.
module booth_seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int AW = WIDTH + 2;
  localparam int MW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   acc;
  logic [MW-1:0]   mcand;
  logic [MW-1:0]   mplier;
  logic            q_m1;
  logic [CW-1:0]   count;

  logic [AW-1:0]   sum;
  logic [AW-1:0]   acc_shift;
  logic [MW-1:0]   mplier_shift;
  logic            last_step;

  assign last_step = (count == CW'(WIDTH));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One Booth step: recode {Q0, Q-1}, then shift {acc, mplier, Q-1} right arithmetically.
  always_comb begin
    sum = acc;
    case ({mplier[0], q_m1})
      2'b10:   sum = acc - {mcand[MW-1], mcand};
      2'b01:   sum = acc + {mcand[MW-1], mcand};
      default: sum = acc;
    endcase
    acc_shift    = {sum[AW-1], sum[AW-1:1]};
    mplier_shift = {sum[0], mplier[MW-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= {is_signed & a[WIDTH-1], a};
            mplier <= {is_signed & b[WIDTH-1], b};
            q_m1   <= 1'b0;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= acc_shift;
          mplier <= mplier_shift;
          q_m1   <= mplier[0];
          count  <= count + 1'b1;
          // The final step's shifted value is the exact product; keep its low 2*WIDTH bits.
          if (last_step) product <= {acc_shift[WIDTH-2:0], mplier_shift};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits, legal range 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  multiplier (Booth-scanned); sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a valid new product.
REQ-010 SHALL have port product  output  2*WIDTH  result register.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE SHALL move to RUN on a rising edge with start=1; a, b, is_signed latched at that edge (edge E0).
REQ-013 Operands SHALL be extended internally to WIDTH+1 bits: sign-extended if is_signed=1, zero-extended if 0.
REQ-014 SHALL use radix-2 Booth recoding: per step, inspect {multiplier LSB, previous bit Q-1}; 10 -> subtract multiplicand from upper accumulator, 01 -> add, 00/11 -> no op; then arithmetic right shift of {acc, multiplier, Q-1}.
REQ-015 Q-1 SHALL be 0 at the start of every operation.
REQ-016 Accumulator SHALL be WIDTH+2 bits to absorb add/subtract overflow before the shift.
REQ-017 RUN SHALL perform exactly one Booth step per clock, WIDTH+1 steps, on edges E1..E(WIDTH+1), via an iteration counter of ceil(log2(WIDTH+2)) bits.
REQ-018 At edge E(WIDTH+1), FSM SHALL enter DONE and load product with the low 2*WIDTH bits of the exact result.
REQ-019 done SHALL be 1 for exactly the cycle after E(WIDTH+1) and 0 at all other times.
REQ-020 At edge E(WIDTH+2), FSM SHALL return to IDLE; busy falls to 0.
REQ-021 busy SHALL be 1 from after E0 through the DONE cycle inclusive.
REQ-022 Total latency SHALL be fixed at WIDTH+2 cycles, start edge to done cycle, independent of operand values and mode.
REQ-023 start in RUN or DONE SHALL be ignored (no queuing); reissue in IDLE required.
REQ-024 Changes on a, b, is_signed after E0 SHALL NOT affect the running operation.
REQ-025 product SHALL hold its value from one DONE until the next DONE; it SHALL NOT change during RUN.
REQ-026 Signed result SHALL be the exact two's-complement product, including the case a = b = -2^(WIDTH-1).
REQ-027 Unsigned result SHALL be the exact product up to (2^WIDTH-1)^2.

Reset
REQ-028 rst=1 SHALL immediately, without a clock, force state IDLE, busy=0, done=0, product=0, counter=0, internal registers=0.
REQ-029 rst asserted mid-RUN or in DONE SHALL abort the operation; no done pulse follows; product reads 0.
REQ-030 First edge with rst=0 and start=1 SHALL be accepted as a normal E0.

Verification (WIDTH=4)
REQ-031 signed, a=3, b=-2 (4'hE) -> done in the 6th cycle after E0, product=8'hFA.
REQ-032 unsigned, a=15, b=15 -> product=8'hE1; same operands signed (-1*-1) -> product=8'h01.
REQ-033 signed, a=-8, b=-8 -> 8'h40; signed a=-8, b=7 -> 8'hC8; a=0, any b -> 8'h00.
REQ-034 start pulsed with new operands on the 2nd RUN cycle and during DONE -> ignored; product=first result; exactly one done pulse.
REQ-035 rst asserted on the 3rd RUN cycle -> busy, done, product=0 immediately; next start completes correctly after WIDTH+2 cycles.
REQ-036 Back-to-back: start held high continuously -> a new operation begins every WIDTH+3 cycles, done pulses one cycle each, products correct.
